// File: rtl/cache_write_buffer.sv
// Single-entry write-back buffer between the L1 cache and physical memory.
// Absorbs dirty evictions, forwards read hits, and drains when the memory port is idle.
module cache_write_buffer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cache_pmem_read,
    input  logic         cache_pmem_write,
    input  logic [15:0]  cache_pmem_address,
    input  logic [127:0] cache_pmem_wdata,
    output logic [127:0] cache_pmem_rdata,
    output logic         cache_pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         buffer_full
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        DRAIN    = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          buf_valid_q, buf_valid_d;
    logic [11:0]   buf_tag_q, buf_tag_d;
    logic [127:0]  buf_data_q, buf_data_d;
    logic [127:0]  rdata_q, rdata_d;
    logic          hit;

    assign hit = buf_valid_q && (cache_pmem_address[15:4] == buf_tag_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                // Reads take priority over writes; a missing read also preempts draining.
                if (cache_pmem_read && hit) begin
                    rdata_d = buf_data_q;
                    state_d = RESP;
                end else if (cache_pmem_read) begin
                    state_d = MEM_READ;
                end else if (cache_pmem_write && (!buf_valid_q || hit)) begin
                    buf_tag_d   = cache_pmem_address[15:4];
                    buf_data_d  = cache_pmem_wdata;
                    buf_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (buf_valid_q) begin
                    // Conflicting write or no request: empty the entry first.
                    state_d = DRAIN;
                end
            end
            MEM_READ: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    buf_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cache_pmem_rdata = '0;
        cache_pmem_resp  = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        buffer_full      = buf_valid_q;
        case (state_q)
            MEM_READ: begin
                pmem_read    = 1'b1;
                pmem_address = cache_pmem_address;
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {buf_tag_q, 4'b0000};
                pmem_wdata   = buf_data_q;
            end
            RESP: begin
                cache_pmem_resp  = 1'b1;
                cache_pmem_rdata = rdata_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Scoreboard bench for cache_write_buffer: directed cache requests, a simple
// two-cycle memory model, and independent monitors on both handshakes.
module tb_cache_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cache_pmem_read;
    logic         cache_pmem_write;
    logic [15:0]  cache_pmem_address;
    logic [127:0] cache_pmem_wdata;
    logic [127:0] cache_pmem_rdata;
    logic         cache_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         buffer_full;

    always #5 clk = ~clk;

    cache_write_buffer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cache_pmem_read    (cache_pmem_read),
        .cache_pmem_write   (cache_pmem_write),
        .cache_pmem_address (cache_pmem_address),
        .cache_pmem_wdata   (cache_pmem_wdata),
        .cache_pmem_rdata   (cache_pmem_rdata),
        .cache_pmem_resp    (cache_pmem_resp),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_address       (pmem_address),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp),
        .buffer_full        (buffer_full)
    );

    typedef struct {
        logic         chk;
        logic [127:0] data;
    } cexp_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } pexp_t;

    cexp_t cq[$];
    pexp_t pq[$];

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] DA = {8{16'hAAAA}};
    localparam logic [127:0] DB = {8{16'hBBBB}};
    localparam logic [127:0] DC = {8{16'hCCCC}};
    localparam logic [127:0] DD = {8{16'hDDDD}};

    logic [127:0] mem_rdata_val;
    int           pcnt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_c(input logic chk, input logic [127:0] d);
        cexp_t e;
        e.chk  = chk;
        e.data = d;
        cq.push_back(e);
    endtask

    task automatic push_p(input logic wr, input logic [15:0] a, input logic [127:0] d);
        pexp_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        pq.push_back(e);
    endtask

    // Memory model: responds two cycles after a request appears.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        pcnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pcnt      = 0;
            end else if (rst_n && (pmem_read || pmem_write)) begin
                pcnt++;
                if (pcnt >= 2) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_rdata_val;
                end
            end else begin
                pcnt = 0;
            end
        end
    end

    // Memory-side monitor: every completed memory transaction must match the next expected one.
    initial begin
        pexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && pmem_resp && (pmem_read || pmem_write)) begin
                check("pmem_rd_wr_exclusive", pmem_read && pmem_write, 0);
                if (pq.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr=%h required none",
                             pmem_read, pmem_write, pmem_address);
                end else begin
                    e = pq.pop_front();
                    check("pmem_kind_is_write", pmem_write, e.wr);
                    check("pmem_address", pmem_address, e.addr);
                    if (e.wr) check("pmem_wdata", pmem_wdata, e.data);
                end
            end
        end
    end

    // Cache-side monitor: each response pops the scoreboard; reads compare data.
    initial begin
        cexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cache_pmem_resp) begin
                check("resp_cycle_pmem_idle", pmem_read | pmem_write, 0);
                if (cq.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL cache_resp_unexpected: got resp=1 required none");
                end else begin
                    e = cq.pop_front();
                    if (e.chk) check("cache_rdata", cache_pmem_rdata, e.data);
                end
            end
        end
    end

    // Issue one cache request at posedge+1 and hold it until resp; return at posedge+1.
    task automatic cache_req(input logic wr, input logic [15:0] a, input logic [127:0] d,
                             input int exp_lat, input string name);
        int lat;
        bit got;
        cache_pmem_read    = !wr;
        cache_pmem_write   = wr;
        cache_pmem_address = a;
        cache_pmem_wdata   = d;
        lat = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cache_pmem_resp) got = 1;
        end
        check({name, "_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        cache_pmem_read  = 1'b0;
        cache_pmem_write = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!buffer_full && !pmem_write) break;
        end
        check({name, "_buffer_empty"}, buffer_full, 0);
        repeat (3) @(negedge clk);
        check({name, "_pmem_all_seen"}, pq.size(), 0);
        check({name, "_cache_all_seen"}, cq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        cache_pmem_read    = 1'b0;
        cache_pmem_write   = 1'b0;
        cache_pmem_address = '0;
        cache_pmem_wdata   = '0;
        mem_rdata_val      = DC;
        repeat (2) @(negedge clk);
        check("rst_cache_resp", cache_pmem_resp, 0);
        check("rst_cache_rdata", cache_pmem_rdata, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_buffer_full", buffer_full, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Absorb then opportunistic drain
        push_c(1'b0, '0);
        push_p(1'b1, 16'h1230, DA);
        cache_req(1'b1, 16'h1230, DA, 2, "t1_write");
        check("t1_buffer_full", buffer_full, 1);
        wait_drain("t1");

        // Write then forwarded read hit on same line
        push_c(1'b0, '0);
        push_c(1'b1, DA);
        push_p(1'b1, 16'h1230, DA);
        cache_req(1'b1, 16'h1230, DA, 2, "t2_write");
        cache_req(1'b0, 16'h1238, '0, 2, "t2_read_hit");
        wait_drain("t2");

        // Conflicting write forces drain before capture
        push_c(1'b0, '0);
        push_c(1'b0, '0);
        push_p(1'b1, 16'h1230, DA);
        push_p(1'b1, 16'h4560, DB);
        cache_req(1'b1, 16'h1230, DA, 2, "t3_write_a");
        cache_req(1'b1, 16'h4560, DB, 5, "t3_write_b");
        check("t3_buffer_full", buffer_full, 1);
        wait_drain("t3");

        // Read miss preempts drain
        push_c(1'b0, '0);
        push_c(1'b1, DC);
        push_p(1'b0, 16'h7770, '0);
        push_p(1'b1, 16'h1230, DA);
        cache_req(1'b1, 16'h1230, DA, 2, "t4_write");
        cache_req(1'b0, 16'h7770, '0, 4, "t4_read_miss");
        wait_drain("t4");

        // Coalescing write hit
        push_c(1'b0, '0);
        push_c(1'b0, '0);
        push_p(1'b1, 16'h1230, DD);
        cache_req(1'b1, 16'h1230, DA, 2, "t5_write_a");
        cache_req(1'b1, 16'h1230, DD, 2, "t5_write_d");
        wait_drain("t5");

        // Reset in the middle of a drain
        push_c(1'b0, '0);
        cache_req(1'b1, 16'h1230, DA, 2, "t6_write");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pmem_write) break;
        end
        check("t6_drain_started", pmem_write, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pmem_write", pmem_write, 0);
        check("t6_rst_pmem_address", pmem_address, 0);
        check("t6_rst_pmem_wdata", pmem_wdata, 0);
        check("t6_rst_buffer_full", buffer_full, 0);
        check("t6_rst_cache_resp", cache_pmem_resp, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t6_post_buffer_full", buffer_full, 0);
        repeat (20) @(negedge clk);
        check("t6_no_pmem_after_reset", pq.size(), 0);
        check("t6_cache_all_seen", cq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Single-entry write-back buffer between the L1 cache datapath/control and physical memory. It presents the same pmem-style handshake upward to the cache as physical memory does. Evicted dirty 128-bit lines are absorbed in one short transaction and drained to memory when the memory port is idle. Line reads that hit the buffered entry are forwarded without a memory access; reads that miss are prioritised over draining.

## Interface
Parameters:
- none; line width 128, address width 16 and line offset 4 bits are fixed by the cache geometry.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cache_pmem_read  in  1  line read request from cache; held until cache_pmem_resp.
- cache_pmem_write  in  1  line write (eviction) request from cache; held until cache_pmem_resp.
- cache_pmem_address  in  16  line address from cache; bits [3:0] ignored for matching.
- cache_pmem_wdata  in  128  eviction line data.
- cache_pmem_rdata  out  128  read line returned to cache; valid while cache_pmem_resp=1.
- cache_pmem_resp  out  1  one-cycle completion pulse to cache.
- pmem_read  out  1  read request to physical memory.
- pmem_write  out  1  write request to physical memory.
- pmem_address  out  16  memory address.
- pmem_wdata  out  128  memory write data.
- pmem_rdata  in  128  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.
- buffer_full  out  1  entry valid (status only).

## Operation
- Storage: buf_valid, buf_tag[15:4], buf_data[127:0], rdata_reg[127:0].
- hit = buf_valid && cache_pmem_address[15:4] == buf_tag.
- FSM states: IDLE, MEM_READ, DRAIN, RESP.
- IDLE priority order:
  - read && hit: rdata_reg <= buf_data; go to RESP.
  - read && !hit: go to MEM_READ.
  - write && (!buf_valid || hit): buf_tag/buf_data <= cache inputs, buf_valid <= 1; go to RESP. A write hit coalesces by overwriting the entry.
  - write && buf_valid && !hit: go to DRAIN. The write is accepted on the later return to IDLE.
  - no request && buf_valid: go to DRAIN (opportunistic drain).
  - otherwise: stay in IDLE.
- MEM_READ:
  - pmem_read=1; pmem_address=cache_pmem_address.
  - On pmem_resp: rdata_reg <= pmem_rdata; go to RESP.
- DRAIN:
  - pmem_write=1; pmem_address={buf_tag,4'b0}; pmem_wdata=buf_data.
  - On pmem_resp: buf_valid <= 0; go to IDLE.
  - A drain, once started, is never aborted. A cache read arriving mid-drain waits.
- RESP:
  - cache_pmem_resp=1; cache_pmem_rdata=rdata_reg.
  - Unconditionally go to IDLE.
  - The requester deasserts its request in the cycle after resp. A request seen in IDLE is a new transaction.
- Simultaneous cache_pmem_read and cache_pmem_write is illegal; read wins.
- pmem_read and pmem_write are never both 1.
- pmem_read/pmem_write deassert in the cycle after pmem_resp.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, rdata_reg=0.
  - All outputs 0; pmem_address=0, pmem_wdata=0, buffer_full=0.
  - Reset mid-DRAIN discards the entry, and the line is lost. This is accepted by design.
- Outputs are combinational from state and registers only; there are no cache-input-to-pmem-request combinational paths except pmem_address in MEM_READ.
- Write absorb or read hit: request sampled in IDLE at edge N; cache_pmem_resp high in cycle N+1. Latency is 2 cycles.
- Read miss with empty buffer: pmem_read asserted from cycle N+1; pmem_resp in cycle M; cache_pmem_resp in cycle M+1.
- Write with a conflicting full entry: the drain completes first (pmem_resp at M), then IDLE at M+1, then capture, then resp at M+2.
- Opportunistic drain starts one cycle after the last cache_pmem_resp if no new request is present.

## Test plan
- Reset then write 0x1230 with data A (128'h…AAAA): cache_pmem_resp pulses 2 cycles later; buffer_full=1; no pmem activity in the resp cycle. With no further requests, a pmem_write to 0x1230 with data A follows, then buffer_full=0.
- Write 0x1230 (A), then immediately read 0x1238: forwarded rdata=A with resp 2 cycles after the read request; pmem_read never asserted.
- Write 0x1230 (A), then immediately write 0x4560 (B): pmem_write 0x1230/A occurs first, then B is captured and cache resp is returned. The buffer then holds 0x4560/B.
- Write 0x1230 (A), then read 0x7770 before the drain starts: pmem_read 0x7770 precedes any pmem_write. The returned pmem_rdata C is delivered to the cache, then the drain of A follows.
- Write 0x1230 (A), then write 0x1230 (D): coalesced, with exactly one pmem_write carrying D.
- Assert rst_n=0 mid-DRAIN: all outputs 0 immediately; buffer_full=0 after release; no pmem_write after reset.
